// File: rtl/int_img_rect_sum_if.sv
// Query, integral-buffer read and result channels of int_img_rect_sum.
// slave is the rectangle-sum block; master is the query source, buffer and consumer.
interface int_img_rect_sum_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int AW = 17
);
  logic          req_valid;
  logic          req_ready;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic [XW-1:0] req_w;
  logic [YW-1:0] req_h;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_sum;
  logic          out_err;

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, rd_data, out_ready,
    output req_ready, rd_en, rd_addr, out_valid, out_sum, out_err
  );

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, rd_data, out_ready,
    input  req_ready, rd_en, rd_addr, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/int_img_rect_sum.sv
// Rectangle sum over an inclusive integral image: fetches D, B, C, A corners
// through a 1-cycle-latency read port and returns D - B - C + A.
module int_img_rect_sum #(
  parameter int WIDTH_LIMIT  = 320,
  parameter int HEIGHT_LIMIT = 240,
  parameter int XW           = $clog2(WIDTH_LIMIT + 1),
  parameter int YW           = $clog2(HEIGHT_LIMIT + 1),
  parameter int AW           = $clog2(WIDTH_LIMIT * HEIGHT_LIMIT)
) (
  input  logic              clock,
  input  logic              reset,
  int_img_rect_sum_if.slave bus
);

  localparam int XE = XW + 1;
  localparam int YE = YW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_e;
  typedef enum logic [1:0] {CORNER_D, CORNER_B, CORNER_C, CORNER_A} corner_e;
  typedef logic [3:0] corner_mask_t;

  state_e        state_q, state_d;
  logic [XW-1:0] x1_q, x1_d;     // right column of the rectangle
  logic [XW-1:0] xl_q, xl_d;     // column just left of the rectangle
  logic [YW-1:0] y1_q, y1_d;     // bottom row of the rectangle
  logic [YW-1:0] yt_q, yt_d;     // row just above the rectangle
  corner_mask_t  pend_q, pend_d; // corners still to read, bit index = corner_e
  logic          rd_inflight_q, rd_inflight_d;
  logic          rd_sub_q, rd_sub_d;
  logic [31:0]   acc_q, acc_d;
  logic          err_q, err_d;

  logic          req_err;
  corner_e       corner;
  logic [XW-1:0] rd_col;
  logic [YW-1:0] rd_row;

  // Widened by one bit so x0+w cannot wrap before the bound compare.
  always_comb begin
    req_err = (bus.req_w == '0) || (bus.req_h == '0)
           || (XE'(bus.req_x) + XE'(bus.req_w) > XE'(WIDTH_LIMIT))
           || (YE'(bus.req_y) + YE'(bus.req_h) > YE'(HEIGHT_LIMIT));
  end

  always_comb begin
    corner = CORNER_A;
    if (pend_q[CORNER_D])      corner = CORNER_D;
    else if (pend_q[CORNER_B]) corner = CORNER_B;
    else if (pend_q[CORNER_C]) corner = CORNER_C;
    rd_row = (corner == CORNER_D || corner == CORNER_C) ? y1_q : yt_q;
    rd_col = (corner == CORNER_D || corner == CORNER_B) ? x1_q : xl_q;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    x1_d          = x1_q;
    xl_d          = xl_q;
    y1_d          = y1_q;
    yt_d          = yt_q;
    pend_d        = pend_q;
    rd_inflight_d = 1'b0;
    rd_sub_d      = 1'b0;
    acc_d         = acc_q;
    err_d         = err_q;
    bus.req_ready = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.out_valid = 1'b0;

    // Data for last cycle's read lands now; B and C carry a negative sign.
    if (rd_inflight_q) begin
      acc_d = rd_sub_q ? acc_q - bus.rd_data : acc_q + bus.rd_data;
    end

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          acc_d  = '0;
          err_d  = req_err;
          x1_d   = bus.req_x + bus.req_w - XW'(1);
          xl_d   = bus.req_x - XW'(1);
          y1_d   = bus.req_y + bus.req_h - YW'(1);
          yt_d   = bus.req_y - YW'(1);
          pend_d = {(bus.req_x != '0) && (bus.req_y != '0),
                    (bus.req_x != '0), (bus.req_y != '0), 1'b1};
          if (req_err) begin
            pend_d  = '0;
            state_d = S_OUT;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        bus.rd_en      = 1'b1;
        bus.rd_addr    = AW'(int'(rd_row) * WIDTH_LIMIT + int'(rd_col));
        rd_inflight_d  = 1'b1;
        rd_sub_d       = (corner == CORNER_B) || (corner == CORNER_C);
        pend_d[corner] = 1'b0;
        if (pend_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out_sum = acc_q;
  assign bus.out_err = err_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x1_q          <= '0;
      xl_q          <= '0;
      y1_q          <= '0;
      yt_q          <= '0;
      pend_q        <= '0;
      rd_inflight_q <= 1'b0;
      rd_sub_q      <= 1'b0;
      acc_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      x1_q          <= x1_d;
      xl_q          <= xl_d;
      y1_q          <= y1_d;
      yt_q          <= yt_d;
      pend_q        <= pend_d;
      rd_inflight_q <= rd_inflight_d;
      rd_sub_q      <= rd_sub_d;
      acc_q         <= acc_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_int_img_rect_sum.sv
// Self-checking bench for int_img_rect_sum on a 4x4 image with a 1-cycle
// integral buffer model; expected sums come from summing pixels directly.
module tb_int_img_rect_sum;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = $clog2(W + 1);
  localparam int YW = $clog2(H + 1);
  localparam int AW = $clog2(W * H);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [31:0]   pix [H][W];
  logic [31:0]   ii  [W*H];
  logic          buf_en = 1'b0;
  logic [AW-1:0] buf_addr = '0;
  int            rd_addr_log[$];
  int            rd_cyc_log[$];
  int            exp_addr[$];

  int_img_rect_sum_if #(.XW(XW), .YW(YW), .AW(AW)) bus ();

  int_img_rect_sum #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read monitor and buffer: sample the request mid-cycle, answer on the next edge.
  always @(negedge clk) begin
    buf_en   = bus.rd_en;
    buf_addr = bus.rd_addr;
    if (bus.rd_en) begin
      rd_addr_log.push_back(int'(bus.rd_addr));
      rd_cyc_log.push_back(cyc);
    end
  end
  always @(posedge clk) bus.rd_data <= buf_en ? ii[buf_addr] : 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  task automatic build_ii();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [31:0] s = 32'd0;
        for (int r = 0; r <= y; r++)
          for (int c = 0; c <= x; c++) s += pix[r][c];
        ii[y*W + x] = s;
      end
  endtask

  task automatic ramp_pixels();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) pix[y][x] = 32'(4*y + x + 1);
    build_ii();
  endtask

  function automatic bit model_err(int x, int y, int w, int h);
    return (w == 0) || (h == 0) || (x + w > W) || (y + h > H);
  endfunction

  function automatic logic [31:0] model_sum(int x, int y, int w, int h);
    logic [31:0] s = 32'd0;
    if (model_err(x, y, w, h)) return 32'd0;
    for (int r = y; r < y + h; r++)
      for (int c = x; c < x + w; c++) s += pix[r][c];
    return s;
  endfunction

  task automatic model_reads(int x, int y, int w, int h);
    exp_addr.delete();
    if (model_err(x, y, w, h)) return;
    exp_addr.push_back((y + h - 1) * W + (x + w - 1));
    if (y > 0) exp_addr.push_back((y - 1) * W + (x + w - 1));
    if (x > 0) exp_addr.push_back((y + h - 1) * W + (x - 1));
    if (x > 0 && y > 0) exp_addr.push_back((y - 1) * W + (x - 1));
  endtask

  function automatic bit reads_ok(int t_acc);
    if (rd_addr_log.size() != exp_addr.size()) return 1'b0;
    foreach (exp_addr[i])
      if (rd_addr_log[i] != exp_addr[i] || rd_cyc_log[i] != t_acc + 1 + i) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic send_query(input int x, input int y, input int w, input int h,
                            output int t_acc);
    int n = 0;
    rd_addr_log.delete();
    rd_cyc_log.delete();
    bus.req_x = XW'(x); bus.req_y = YW'(y);
    bus.req_w = XW'(w); bus.req_h = YW'(h);
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", n);
    end
    t_acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t_valid);
    int n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL valid_timeout: out_valid low for %0d cycles, required high", n);
    end
    t_valid = cyc;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.out_ready = 1'b0;
    bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
    ramp_pixels();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rd_en, bus.out_valid, bus.out_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/en/val/err=%b required 1000",
               {bus.req_ready, bus.rd_en, bus.out_valid, bus.out_err});
    end
    checks++;
    if (bus.rd_addr !== '0 || bus.out_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d sum=%0d required 0/0", bus.rd_addr, bus.out_sum);
    end
  endtask

  task automatic test_four_read();
    int t, tv;
    send_query(1, 1, 2, 2, t);
    model_reads(1, 1, 2, 2);
    wait_valid(tv);
    checks++;
    if (tv !== t + 6) begin
      errors++; $display("FAIL four_latency: got T+%0d required T+6", tv - t);
    end
    checks++;
    if (bus.out_sum !== 32'd34 || bus.out_err !== 1'b0) begin
      errors++; $display("FAIL four_sum: got %0d err=%b required 34 err=0", bus.out_sum, bus.out_err);
    end
    checks++;
    if (!reads_ok(t)) begin
      errors++; $display("FAIL four_reads: got %p required %p", rd_addr_log, exp_addr);
    end
    handshake();
  endtask

  task automatic test_single_read();
    int t, tv;
    bus.out_ready = 1'b1;
    send_query(0, 0, 4, 4, t);
    model_reads(0, 0, 4, 4);
    wait_valid(tv);
    checks++;
    if (tv !== t + 3 || bus.out_sum !== 32'd136) begin
      errors++; $display("FAIL single_sum: got T+%0d sum=%0d required T+3 sum=136", tv - t, bus.out_sum);
    end
    checks++;
    if (!reads_ok(t)) begin
      errors++; $display("FAIL single_reads: got %p required %p", rd_addr_log, exp_addr);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (cyc !== t + 4 || bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_ready: got T+%0d rdy=%b val=%b required T+4 rdy=1 val=0",
                         cyc - t, bus.req_ready, bus.out_valid);
    end
  endtask

  task automatic test_two_read();
    int t, tv;
    int qx[2] = '{2, 0};
    int qy[2] = '{0, 2};
    int qw[2] = '{2, 1};
    int qh[2] = '{1, 2};
    logic [31:0] qs[2] = '{32'd7, 32'd22};
    for (int i = 0; i < 2; i++) begin
      send_query(qx[i], qy[i], qw[i], qh[i], t);
      model_reads(qx[i], qy[i], qw[i], qh[i]);
      wait_valid(tv);
      checks++;
      if (tv !== t + 4 || bus.out_sum !== qs[i] || bus.out_err !== 1'b0) begin
        errors++; $display("FAIL two_sum[%0d]: got T+%0d sum=%0d err=%b required T+4 sum=%0d err=0",
                           i, tv - t, bus.out_sum, bus.out_err, qs[i]);
      end
      checks++;
      if (!reads_ok(t)) begin
        errors++; $display("FAIL two_reads[%0d]: got %p required %p", i, rd_addr_log, exp_addr);
      end
      handshake();
    end
  endtask

  task automatic test_invalid();
    int t, tv;
    int qx[2] = '{3, 0};
    int qw[2] = '{2, 0};
    int qh[2] = '{1, 3};
    for (int i = 0; i < 2; i++) begin
      send_query(qx[i], 0, qw[i], qh[i], t);
      wait_valid(tv);
      checks++;
      if (tv !== t + 1 || bus.out_sum !== 32'd0 || bus.out_err !== 1'b1) begin
        errors++; $display("FAIL invalid[%0d]: got T+%0d sum=%0d err=%b required T+1 sum=0 err=1",
                           i, tv - t, bus.out_sum, bus.out_err);
      end
      handshake();
      checks++;
      if (rd_addr_log.size() != 0) begin
        errors++; $display("FAIL invalid_reads[%0d]: got %0d reads required 0", i, rd_addr_log.size());
      end
    end
  endtask

  task automatic test_backpressure();
    int t, tv, t2, tv2;
    send_query(0, 0, 4, 4, t);
    wait_valid(tv);
    // A competing query sits on the request port while the result is held.
    bus.req_x = XW'(2); bus.req_y = '0; bus.req_w = XW'(2); bus.req_h = YW'(1);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.out_err, bus.out_sum} !== {1'b1, 1'b0, 32'd136}) begin
        errors++; $display("FAIL bp_hold[%0d]: got val=%b err=%b sum=%0d required 1/0/136",
                           i, bus.out_valid, bus.out_err, bus.out_sum);
      end
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b required 0", i, bus.req_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (rd_addr_log.size() != 1) begin
      errors++; $display("FAIL bp_no_accept: got %0d reads required 1", rd_addr_log.size());
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    rd_addr_log.delete();
    rd_cyc_log.delete();
    t2 = cyc;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b val=%b required 1/0", bus.req_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    model_reads(2, 0, 2, 1);
    wait_valid(tv2);
    checks++;
    if (tv2 !== t2 + 4 || bus.out_sum !== 32'd7) begin
      errors++; $display("FAIL bp_next: got T+%0d sum=%0d required T+4 sum=7", tv2 - t2, bus.out_sum);
    end
    checks++;
    if (!reads_ok(t2)) begin
      errors++; $display("FAIL bp_next_reads: got %p required %p", rd_addr_log, exp_addr);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int t, tv;
    send_query(1, 1, 2, 2, t);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rd_en, bus.out_valid, bus.out_err} !== 4'b1000 ||
        bus.rd_addr !== '0 || bus.out_sum !== 32'd0) begin
      errors++; $display("FAIL midreset_state: got rdy/en/val/err=%b addr=%0d sum=%0d required 1000/0/0",
                         {bus.req_ready, bus.rd_en, bus.out_valid, bus.out_err}, bus.rd_addr, bus.out_sum);
    end
    @(negedge clk);
    checks++;
    if (bus.out_sum !== 32'd0 || bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++; $display("FAIL midreset_stale: got sum=%0d val=%b en=%b required 0/0/0",
                         bus.out_sum, bus.out_valid, bus.rd_en);
    end
    send_query(1, 1, 2, 2, t);
    wait_valid(tv);
    checks++;
    if (tv !== t + 6 || bus.out_sum !== 32'd34) begin
      errors++; $display("FAIL midreset_after: got T+%0d sum=%0d required T+6 sum=34", tv - t, bus.out_sum);
    end
    handshake();
  endtask

  task automatic test_random();
    int x, y, w, h, t, tv, lat;
    bit e;
    logic [31:0] s;
    for (int y0 = 0; y0 < H; y0++)
      for (int x0 = 0; x0 < W; x0++) pix[y0][x0] = $urandom;
    build_ii();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(0, W - 1); w = $urandom_range(1, W - x);
        y = $urandom_range(0, H - 1); h = $urandom_range(1, H - y);
      end else begin
        x = $urandom_range(0, W); w = $urandom_range(0, W);
        y = $urandom_range(0, H); h = $urandom_range(0, H);
      end
      e = model_err(x, y, w, h);
      s = model_sum(x, y, w, h);
      model_reads(x, y, w, h);
      lat = e ? 1 : exp_addr.size() + 2;
      send_query(x, y, w, h, t);
      wait_valid(tv);
      checks++;
      if (bus.out_err !== e || bus.out_sum !== s) begin
        errors++; $display("FAIL rnd_result[%0d] (%0d,%0d,%0d,%0d): got sum=%0h err=%b required sum=%0h err=%b",
                           n, x, y, w, h, bus.out_sum, bus.out_err, s, e);
      end
      checks++;
      if (tv !== t + lat) begin
        errors++; $display("FAIL rnd_latency[%0d]: got T+%0d required T+%0d", n, tv - t, lat);
      end
      checks++;
      if (!reads_ok(t)) begin
        errors++; $display("FAIL rnd_reads[%0d]: got %p required %p", n, rd_addr_log, exp_addr);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_four_read();
    test_single_read();
    test_two_read();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_img_rect_sum.md
Name: int_img_rect_sum

Overview:
- Read-side consumer of the integral image buffer.
- Accepts one rectangle query at a time and fetches the needed corner values through a single-port synchronous read interface.
- Computes the rectangle pixel sum as D − B − C + A and returns it with a valid/ready handshake.
- Sits between the integral image storage and the Viola-Jones feature evaluators; used for feature rectangles and window-sum normalisation.

Parameters:
- WIDTH_LIMIT, `LAPTOP_WIDTH (vj_weights.vh): image width in pixels.
- HEIGHT_LIMIT, `LAPTOP_HEIGHT (vj_weights.vh): image height in pixels.
- XW, $clog2(WIDTH_LIMIT+1): width of x/w fields.
- YW, $clog2(HEIGHT_LIMIT+1): width of y/h fields.
- AW, $clog2(WIDTH_LIMIT*HEIGHT_LIMIT): read address width.

Ports:
- clock  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  query present.
- req_ready  out  1  block can accept a query; high only in IDLE.
- req_x  in  XW  top-left column x0.
- req_y  in  YW  top-left row y0.
- req_w  in  XW  rectangle width.
- req_h  in  YW  rectangle height.
- rd_en  out  1  read strobe to integral image buffer.
- rd_addr  out  AW  address = y*WIDTH_LIMIT + x.
- rd_data  in  32  integral value; valid exactly 1 cycle after rd_en.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  32  rectangle sum.
- out_err  out  1  query was out of bounds or empty.

Behaviour:
- Integral image is inclusive: II[y][x] = sum of pixels rows 0..y, cols 0..x.
- Corner coordinates: x1 = x0+w−1, y1 = y0+h−1.
  - D = II[y1][x1]
  - B = II[y0−1][x1], fetched only if y0>0
  - C = II[y1][x0−1], fetched only if x0>0
  - A = II[y0−1][x0−1], fetched only if x0>0 and y0>0
  - Corners not fetched contribute 0.
- Read issue order: D, B, C, A, skipping absent corners, one read per cycle, back-to-back.
- k = number of reads: 1, 2 or 4.
- Arithmetic: 32-bit modular. Accumulator is cleared on accept; D and A are added, B and C subtracted, as each rd_data returns. The result is exact for legal images.
- Error check on accept: w==0, h==0, x0+w>WIDTH_LIMIT or y0+h>HEIGHT_LIMIT sets err. On err: no reads issued, out_sum=0, out_err=1.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch the query; go to ISSUE, or to OUT on err.
  - ISSUE: assert rd_en once per cycle for each required corner. After the last read, go to DRAIN.
  - DRAIN: one cycle absorbing the final rd_data; go to OUT.
  - OUT: out_valid=1. out_sum/out_err held stable until out_ready; on out_valid&&out_ready go to IDLE.
- Latency (accept at cycle T):
  - Reads occur in cycles T+1..T+k.
  - out_valid first high at T+k+2.
  - For err, out_valid is high at T+1.
- Throughput: no new query is accepted while OUT is held (req_ready=0). The next accept is possible the cycle after the out handshake.
- rd_en is low in IDLE, DRAIN and OUT. rd_addr is don't-care when rd_en=0 but is driven to 0.
- Reset, at any point including mid-ISSUE or DRAIN:
  - Next state is IDLE.
  - req_ready=1, rd_en=0, rd_addr=0, out_valid=0, out_sum=0, out_err=0, accumulator=0.
  - rd_data arriving the cycle after reset is ignored.
- req_valid asserted while not IDLE: ignored, no side effects.
- out_ready with out_valid=0: ignored.

Test Plan (WIDTH_LIMIT=HEIGHT_LIMIT=4, pixel p[y][x]=4y+x+1, buffer model with 1-cycle read latency):
- Query (x0=1,y0=1,w=2,h=2) -> reads addr 10,2,8,0 in that order in cycles T+1..T+4; out_valid at T+6, out_sum=34 (54−6−15+1), out_err=0.
- Query (0,0,4,4) with out_ready=1 -> single read addr 15 at T+1; out_sum=136 at T+3; req_ready high again at T+4.
- Query (2,0,2,1) -> reads addr 3, then 1; out_sum=7 (10−3) at T+4. Query (0,2,1,2) -> reads addr 12, then 4; out_sum=9+13=22.
- Invalid queries (3,0,2,1) and (0,0,0,3) -> no rd_en ever; out_valid at T+1, out_sum=0, out_err=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_sum/out_err stable, req_ready=0, and a concurrent req_valid is not accepted; the next query is accepted only after the handshake.
- Reset asserted one cycle after the second read of a 4-read query -> next cycle IDLE with all outputs at reset values; the stale rd_data is discarded; a following query (1,1,2,2) still yields 34.
